// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: shares the register file write port among NREQ core
// write-back requesters and a debug port, registers the winning write for one
// cycle, and tracks outstanding long-latency destinations in a scoreboard.
module gpr_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic              dbg_we_i,
  input  logic [AW-1:0]     dbg_addr_i,
  input  logic [DW-1:0]     dbg_data_i,
  output logic              dbg_ready_o,
  input  logic              alloc_i,
  input  logic [AW-1:0]     alloc_addr_i,
  output logic              we_o,
  output logic [AW-1:0]     waddr_o,
  output logic [DW-1:0]     wdata_o,
  output logic [31:0]       pending_mask_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] core_gnt;
  logic            core_hit;
  logic [PW-1:0]   win_idx;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;
  logic [31:0]     pend_q;

  // Round-robin search starting at the pointer; debug or reset suppresses core grants
  always_comb begin
    int idx;
    core_gnt = '0;
    core_hit = 1'b0;
    win_idx  = '0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!core_hit && req_valid_i[idx]) begin
        core_hit = 1'b1;
        win_idx  = PW'(idx);
      end
    end
    if (!rst_n || dbg_we_i) core_hit = 1'b0;
    if (core_hit) core_gnt[win_idx] = 1'b1;
  end

  assign req_ready_o = core_gnt;
  assign dbg_ready_o = rst_n & dbg_we_i;
  assign xfer        = dbg_ready_o | core_hit;

  // Route the winner's address and data toward the output register
  always_comb begin
    sel_addr = dbg_addr_i;
    sel_data = dbg_data_i;
    if (!dbg_we_i) begin
      sel_addr = req_addr_i[int'(win_idx)*AW +: AW];
      sel_data = req_data_i[int'(win_idx)*DW +: DW];
    end
  end

  // Scoreboard set/clear decode; x0 is never tracked
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int r = 1; r < 32; r++) begin
      set_mask[r] = alloc_i && (alloc_addr_i == AW'(r));
      clr_mask[r] = xfer && (sel_addr == AW'(r));
    end
  end

  // Output register, pointer advance and scoreboard update (set beats clear)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
      ptr_q   <= '0;
      pend_q  <= '0;
    end else begin
      we_o <= xfer && (sel_addr != '0);
      if (xfer) begin
        waddr_o <= sel_addr;
        wdata_o <= sel_data;
      end
      if (core_hit) begin
        ptr_q <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      end
      pend_q <= (pend_q & ~clr_mask) | set_mask;
    end
  end

  assign pending_mask_o = pend_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_gpr_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic              dbg_we;
  logic [AW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_data;
  logic              dbg_ready;
  logic              alloc;
  logic [AW-1:0]     alloc_addr;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [31:0]       pend;

  // per-requester stimulus, packed onto the DUT buses
  logic          va [NREQ];
  logic [AW-1:0] aa [NREQ];
  logic [DW-1:0] da [NREQ];

  int n_cmp  = 0;
  int n_fail = 0;

  // behavioural model state
  bit              m_ok = 1'b0;
  int              m_ptr;
  logic            m_we;
  logic [AW-1:0]   m_waddr;
  logic [DW-1:0]   m_wdata;
  bit              m_pend [32];
  logic [NREQ-1:0] lg;

  gpr_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready),
    .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_data_i(dbg_data),
    .dbg_ready_o(dbg_ready),
    .alloc_i(alloc), .alloc_addr_i(alloc_addr),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata), .pending_mask_o(pend)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_valid[k]          = va[k];
      req_addr[k*AW +: AW]  = aa[k];
      req_data[k*DW +: DW]  = da[k];
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Winner under the arbitration rules: -1 none, NREQ = debug, else requester index
  function automatic int exp_winner();
    if (!rst_n) return -1;
    if (dbg_we) return NREQ;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (m_ptr + i) % NREQ;
      if (va[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_pend[r];
    return v;
  endfunction

  // Model advance at each clock edge
  always @(posedge clk) begin
    int w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w  = exp_winner();
    lg = '0;
    if (!rst_n) begin
      m_ok = 1'b1; m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    end else begin
      m_we = 1'b0;
      if (w >= 0) begin
        a = (w == NREQ) ? dbg_addr : aa[w];
        d = (w == NREQ) ? dbg_data : da[w];
        m_we = (a != 0); m_waddr = a; m_wdata = d;
        if (a != 0) m_pend[a] = 1'b0;
        if (w < NREQ) begin
          lg[w] = 1'b1;
          m_ptr = (w + 1) % NREQ;
        end
      end
      if (alloc && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
    end
  end

  // Compare DUT against model every cycle, mid-period
  always @(negedge clk) begin
    int w;
    logic [NREQ-1:0] er;
    if (m_ok) begin
      w  = exp_winner();
      er = '0;
      if (w >= 0 && w < NREQ) er[w] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(er));
      check("dbg_ready", 64'(dbg_ready), 64'(w == NREQ));
      check("we", 64'(we), 64'(m_we));
      check("waddr", 64'(waddr), 64'(m_waddr));
      check("wdata", 64'(wdata), 64'(m_wdata));
      check("pending", 64'(pend), 64'(m_pend_vec()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] psave;
    rst_n = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_data = '0;
    alloc = 1'b0; alloc_addr = '0;
    for (int k = 0; k < NREQ; k++) begin
      va[k] = 1'b1; aa[k] = AW'(k + 1); da[k] = 32'h100 + k;
    end

    // reset with every requester valid
    tick(); tick();
    @(negedge clk);
    check("lit_rst_ready", 64'(req_ready), 64'h0);
    check("lit_rst_we", 64'(we), 64'h0);
    check("lit_rst_pend", 64'(pend), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("lit_first_gnt", 64'(req_ready), 64'h1);

    // round-robin with all three valid
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("lit_rr_we", 64'(we), 64'h1);
      check("lit_rr_waddr", 64'(waddr), 64'((i % 3) + 1));
      check("lit_rr_ready", 64'(req_ready), 64'(1 << ((i + 1) % 3)));
    end

    // single write from requester 1
    tick();
    va[0] = 1'b0; va[2] = 1'b0; va[1] = 1'b1; aa[1] = 5; da[1] = 32'hDEADBEEF;
    @(negedge clk);
    check("lit_single_ready", 64'(req_ready), 64'h2);
    tick(); va[1] = 1'b0;
    @(negedge clk);
    check("lit_single_we", 64'(we), 64'h1);
    check("lit_single_waddr", 64'(waddr), 64'd5);
    check("lit_single_wdata", 64'(wdata), 64'hDEADBEEF);
    tick();
    @(negedge clk);
    check("lit_single_idle", 64'(we), 64'h0);

    // debug priority with pointer at 2
    tick();
    dbg_we = 1'b1; dbg_addr = 7; dbg_data = 32'hD0D0;
    va[0] = 1'b1; aa[0] = 10; da[0] = 32'hA;
    va[2] = 1'b1; aa[2] = 11; da[2] = 32'hB;
    @(negedge clk);
    check("lit_dbg_ready", 64'(dbg_ready), 64'h1);
    check("lit_dbg_core", 64'(req_ready), 64'h0);
    tick(); dbg_we = 1'b0;
    @(negedge clk);
    check("lit_dbg_next", 64'(req_ready), 64'h4);
    check("lit_dbg_waddr", 64'(waddr), 64'd7);
    tick(); va[2] = 1'b0;
    @(negedge clk);
    check("lit_dbg_w2", 64'(waddr), 64'd11);
    check("lit_dbg_r0", 64'(req_ready), 64'h1);
    tick(); va[0] = 1'b0;
    @(negedge clk);
    check("lit_dbg_w0", 64'(waddr), 64'd10);

    // write to x0
    tick(); va[0] = 1'b1; aa[0] = 0; da[0] = 32'h1234;
    @(negedge clk);
    check("lit_x0_ready", 64'(req_ready), 64'h1);
    psave = pend;
    tick(); va[0] = 1'b0;
    @(negedge clk);
    check("lit_x0_we", 64'(we), 64'h0);
    check("lit_x0_pend", 64'(pend), 64'(psave));

    // scoreboard: set wins over a same-cycle clear, later clear takes effect
    tick(); alloc = 1'b1; alloc_addr = 9;
    tick(); alloc = 1'b0;
    @(negedge clk);
    check("lit_sb_set", 64'(pend[9]), 64'h1);
    tick();
    tick(); va[2] = 1'b1; aa[2] = 9; da[2] = 32'h99; alloc = 1'b1; alloc_addr = 9;
    @(negedge clk);
    check("lit_sb_gnt", 64'(req_ready), 64'h4);
    tick(); va[2] = 1'b0; alloc = 1'b0;
    @(negedge clk);
    check("lit_sb_keep", 64'(pend[9]), 64'h1);
    check("lit_sb_waddr", 64'(waddr), 64'd9);
    tick(); va[1] = 1'b1; aa[1] = 9; da[1] = 32'h77;
    tick(); va[1] = 1'b0;
    @(negedge clk);
    check("lit_sb_clr_we", 64'(we), 64'h1);
    check("lit_sb_clr", 64'(pend[9]), 64'h0);

    // randomized traffic obeying the hold-until-ready rule
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 249) != 0);
      for (int k = 0; k < NREQ; k++) begin
        if (!va[k] || lg[k]) begin
          va[k] = ($urandom_range(0, 3) != 0);
          aa[k] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, 31));
          da[k] = $urandom;
        end
      end
      dbg_we     = ($urandom_range(0, 7) == 0);
      dbg_addr   = AW'($urandom_range(0, 31));
      dbg_data   = $urandom;
      alloc      = ($urandom_range(0, 2) == 0);
      alloc_addr = AW'($urandom_range(0, 31));
    end

    tick();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
